// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : core_pkg
//  Brief    : Shared types and constants for the fetch-redirect logic.
//  Revision : 1.0  initial release
// ============================================================================
package core_pkg;

  // Redirect FSM: RUN fetches normally, PENDING holds a redirect across a stall.
  typedef enum logic [0:0] {
    RUN     = 1'b0,
    PENDING = 1'b1
  } pc_state_e;

  // Sequential fetch stride in bytes.
  localparam logic [31:0] PC_INCR = 32'd4;

  // Instruction fetch is word aligned; the low two target bits are dropped.
  function automatic logic [31:0] alignWord(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage : core_pkg
`default_nettype wire

// File: rtl/pc_redirect_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : pc_redirect_unit_if
//  Brief    : Hazard/EX control inputs and fetch-address outputs of the
//             PC redirect unit.
//  Revision : 1.0  initial release
// ============================================================================
interface pc_redirect_unit_if;

  logic        stall_i;
  logic        BranchTaken_i;
  logic        Jump_i;
  logic [31:0] target_addr_i;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        flush_o;
  logic        redirect_pending_o;
  logic        misalign_o;
  logic [31:0] taken_cnt_o;

  // Pipeline side: drives hazard and resolution info, consumes fetch address.
  modport master (
    output stall_i, BranchTaken_i, Jump_i, target_addr_i,
    input  pc_o, pc_plus4_o, flush_o, redirect_pending_o, misalign_o, taken_cnt_o
  );

  // Redirect unit side.
  modport slave (
    input  stall_i, BranchTaken_i, Jump_i, target_addr_i,
    output pc_o, pc_plus4_o, flush_o, redirect_pending_o, misalign_o, taken_cnt_o
  );

endinterface : pc_redirect_unit_if
`default_nettype wire

// File: rtl/pc_redirect_unit.sv
`default_nettype none
// ============================================================================
//  Module   : pc_redirect_unit
//  Brief    : Fetch PC register with branch/jump redirect, flush generation
//             and a pending slot that holds a redirect across a stall.
//  Revision : 1.0  initial release
// ============================================================================
module pc_redirect_unit
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  wire               clk,
  input  wire               rst_n,
  pc_redirect_unit_if.slave bus
);

  // Low bits forced to zero so the fetch address is always word aligned.
  localparam logic [31:0] c_resetPc = {RESET_PC[31:2], 2'b00};

  pc_state_e   r_state;
  pc_state_e   w_nextState;
  logic [31:0] r_pc;
  logic [31:0] w_nextPc;
  logic [31:0] r_pendPc;
  logic [31:0] w_nextPendPc;
  logic [31:0] r_takenCnt;
  logic        w_redirectReq;
  logic        w_accept;
  logic        w_flush;
  logic [31:0] w_alignedTarget;

  assign w_redirectReq   = bus.BranchTaken_i | bus.Jump_i;
  assign w_alignedTarget = alignWord(bus.target_addr_i);

  // Next-state, next-PC and flush decode; redirects arriving in PENDING are
  // dropped because the younger instructions are already being flushed.
  always_comb begin
    w_nextState  = r_state;
    w_nextPc     = r_pc;
    w_nextPendPc = r_pendPc;
    w_accept     = 1'b0;
    w_flush      = 1'b0;
    case (r_state)
      RUN: begin
        if (w_redirectReq) begin
          w_accept = 1'b1;
          w_flush  = 1'b1;
          if (bus.stall_i) begin
            w_nextPendPc = w_alignedTarget;
            w_nextState  = PENDING;
          end else begin
            w_nextPc = w_alignedTarget;
          end
        end else if (!bus.stall_i) begin
          w_nextPc = r_pc + PC_INCR;
        end
      end
      PENDING: begin
        w_flush = 1'b1;
        if (!bus.stall_i) begin
          w_nextPc    = r_pendPc;
          w_nextState = RUN;
        end
      end
      default: begin
        w_nextState = RUN;
      end
    endcase
  end

  // State, PC, pending target and redirect counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= RUN;
      r_pc       <= c_resetPc;
      r_pendPc   <= 32'd0;
      r_takenCnt <= 32'd0;
    end else begin
      r_state  <= w_nextState;
      r_pc     <= w_nextPc;
      r_pendPc <= w_nextPendPc;
      if (w_accept) begin
        r_takenCnt <= r_takenCnt + 32'd1;
      end
    end
  end

  // Control outputs are gated by reset so that they read zero while reset is
  // held, even though the RUN decode would otherwise react to live inputs.
  assign bus.pc_o               = r_pc;
  assign bus.pc_plus4_o         = r_pc + PC_INCR;
  assign bus.flush_o            = w_flush & rst_n;
  assign bus.redirect_pending_o = (r_state == PENDING) & rst_n;
  assign bus.misalign_o         = w_accept & bus.target_addr_i[1] & rst_n;
  assign bus.taken_cnt_o        = r_takenCnt;

endmodule : pc_redirect_unit
`default_nettype wire

// File: doc/pc_redirect_unit.md
PC_REDIRECT_UNIT -- requirements
Module: pc_redirect_unit

Interface
REQ-001 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC value loaded on reset.
REQ-003 clk  input  1  core clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 stall_i  input  1  hazard-unit hold; PC SHALL NOT advance while high.
REQ-006 BranchTaken_i  input  1  conditional branch resolved taken in EX.
REQ-007 Jump_i  input  1  JAL/JALR resolved in EX.
REQ-008 target_addr_i  input  32  branch/jump target computed in EX.
REQ-009 pc_o  output  32  current fetch address.
REQ-010 pc_plus4_o  output  32  pc_o + 4, modulo 2^32.
REQ-011 flush_o  output  1  kill IF/ID and ID/EX contents this cycle.
REQ-012 redirect_pending_o  output  1  high while in state PENDING.
REQ-013 misalign_o  output  1  one-cycle pulse when an accepted target has bit 1 set.
REQ-014 taken_cnt_o  output  32  count of accepted redirects.

Function
REQ-015 redirect_req SHALL be BranchTaken_i OR Jump_i.
REQ-016 The FSM SHALL have exactly two states, RUN and PENDING.
REQ-017 RUN, redirect_req=0, stall_i=0: pc SHALL become pc+4 at the next edge.
REQ-018 RUN, redirect_req=0, stall_i=1: pc SHALL hold.
REQ-019 RUN, redirect_req=1, stall_i=0: pc SHALL become {target_addr_i[31:2],2'b00} at the next edge, flush_o SHALL be 1 in the same cycle (combinational), and the state SHALL remain RUN.
REQ-020 RUN, redirect_req=1, stall_i=1: the aligned target SHALL be latched into pend_pc, pc SHALL hold, flush_o SHALL be 1, and the state SHALL become PENDING.
REQ-021 PENDING, stall_i=1: pc SHALL hold and flush_o SHALL be 1 every cycle.
REQ-022 PENDING, stall_i=0: pc SHALL become pend_pc at the next edge, flush_o SHALL be 1 in that cycle, and the state SHALL become RUN.
REQ-023 In PENDING, redirect_req SHALL be ignored, because younger instructions are already flushed.
REQ-024 An accepted redirect (REQ-019, REQ-020) SHALL increment taken_cnt_o by 1, wrapping from 32'hFFFF_FFFF to 0; ignored redirects SHALL NOT count.
REQ-025 misalign_o SHALL be 1 for exactly the cycle of an accepted redirect with target_addr_i[1]=1; target bit 0 SHALL be discarded silently.
REQ-026 flush_o SHALL be 0 whenever no redirect is accepted and the state is RUN.
REQ-027 pc_o[1:0] SHALL always be 2'b00.
REQ-028 pc+4 from 32'hFFFF_FFFC SHALL wrap to 32'h0000_0000.

Reset
REQ-029 rst_n=0 SHALL immediately force: pc_o=RESET_PC, state=RUN, pend_pc=0, taken_cnt_o=0.
REQ-030 While rst_n=0, flush_o, misalign_o and redirect_pending_o SHALL all be 0.
REQ-031 Reset asserted while in PENDING SHALL discard pend_pc, with no redirect afterwards.
REQ-032 In the first cycle after reset release, pc_o SHALL equal RESET_PC.

Structure
REQ-033 Enum pc_state_e (RUN, PENDING) and constant PC_INCR=4 SHALL live in core_pkg.
REQ-034 The block SHALL be a single module with no sub-modules, with next-PC logic in one always_comb and state in one always_ff.

Verification
REQ-035 Reset release, no stall or redirect for 3 cycles -> pc_o = 0, 4, 8, 12; flush_o=0 throughout.
REQ-036 At pc=0x10, BranchTaken_i=1, target=0x80, stall_i=0 -> flush_o=1 that cycle; next pc_o=0x80; taken_cnt_o=1.
REQ-037 Jump_i=1, target=0x200, stall_i=1 for 3 cycles, then 0 -> redirect_pending_o=1 for 3 cycles with flush_o=1 for 4 cycles; pc_o=0x200 after release.
REQ-038 In PENDING, BranchTaken_i=1 with target=0x400 -> ignored; pc_o=pend_pc after release; taken_cnt_o incremented once only.
REQ-039 Jump_i=1, target=0x103 -> pc_o=0x100, misalign_o pulses once.
REQ-040 rst_n low for 1 cycle while PENDING -> pc_o=RESET_PC, redirect_pending_o=0, taken_cnt_o=0, no later redirect.
